// File: rtl/struct_if_pkg.sv
// Shared types for the struct-carrying interface I and its writer.
package struct_if_pkg;

  localparam int unsigned DATA_W = 8;

  typedef struct {
    logic [DATA_W-1:0] data;
  } data_t;

endpackage

// File: rtl/I.sv
// Point-to-point struct channel: P1 drives the payload, P2 observes it.
interface I;
  import struct_if_pkg::*;

  data_t data;

  modport P1 (output data);
  modport P2 (input data);
endinterface

// File: rtl/struct_fifo_ctrl.sv
// FIFO bookkeeping: pointers, occupancy and the push/pop handshakes.
module struct_fifo_ctrl #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_valid,
  input  logic          i_pop,
  output logic          o_wr_ready,
  output logic          o_valid,
  output logic [CW-1:0] o_count,
  output logic          o_push,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_rd_ptr
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Handshake qualification; ready is held low throughout reset.
  always_comb begin
    o_wr_ready = i_rst_n && (count_q != CW'(DEPTH));
    o_valid    = (count_q != '0);
    push       = i_wr_valid && o_wr_ready;
    pop        = i_pop && o_valid;
  end

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_count  = count_q;
  assign o_push   = push;
  assign o_wr_ptr = wr_ptr_q;
  assign o_rd_ptr = rd_ptr_q;

endmodule

// File: rtl/struct_if_fifo_writer.sv
// Byte FIFO whose head is presented as a data_t on the P1 side of interface I.
module struct_if_fifo_writer
  import struct_if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  I.P1                      p1,
  output logic              o_valid,
  input  logic              i_pop,
  output logic [CW-1:0]     o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              push;
  logic [PW-1:0]     wr_ptr, rd_ptr;

  struct_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_valid (i_wr_valid),
    .i_pop      (i_pop),
    .o_wr_ready (o_wr_ready),
    .o_valid    (o_valid),
    .o_count    (o_count),
    .o_push     (push),
    .o_wr_ptr   (wr_ptr),
    .o_rd_ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; empty slots are masked on the output.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  // Head presentation; zeros while empty so the reader never sees X.
  always_comb begin
    p1.data.data = '0;
    if (o_valid) p1.data.data = mem[rd_ptr];
  end

endmodule

// File: tb/tb_struct_if_fifo_writer.sv
module tb_struct_if_fifo_writer;
  import struct_if_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_wr_valid = 1'b0;
  logic [7:0]    i_wr_data = 8'h00;
  logic          o_wr_ready;
  logic          o_valid;
  logic          i_pop = 1'b0;
  logic [CW-1:0] o_count;

  I u_I ();

  struct_if_fifo_writer #(
    .DEPTH (DEPTH)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .p1         (u_I),
    .o_valid    (o_valid),
    .i_pop      (i_pop),
    .o_count    (o_count)
  );

  always #5 i_clk = ~i_clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] obs_head;
  logic [7:0] exp_head;
  bit         popped;

  // Applies one cycle of stimulus and updates the scoreboard from the bench's
  // own occupancy model. Called just after a rising edge; returns likewise.
  task automatic drive(input logic v, input logic [7:0] d, input logic pop);
    bit acc_push;
    i_wr_valid = v;
    i_wr_data  = d;
    i_pop      = pop;
    #1;
    obs_head = u_I.data.data;
    popped   = 1'b0;
    if (i_rst_n) begin
      acc_push = v && (sb.size() < DEPTH);
      if (pop && sb.size() != 0) begin
        exp_head = sb.pop_front();
        popped   = 1'b1;
      end
      if (acc_push) sb.push_back(d);
    end else begin
      sb.delete();
    end
    @(posedge i_clk);
    #1;
    i_wr_valid = 1'b0;
    i_pop      = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h56, 1'b0);
    n_vec++;
    if (o_count !== CW'(0) || o_valid !== 1'b0 || u_I.data.data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: count=%0d valid=%b data=%h, want 0/0/00",
               o_count, o_valid, u_I.data.data);
    end
    n_vec++;
    if (o_wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_low: wr_ready=%b, want 0", o_wr_ready);
    end
    i_rst_n = 1'b1;
    #1;
    n_vec++;
    if (o_wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_release: wr_ready=%b, want 1", o_wr_ready);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA5, 1'b0);
    n_vec++;
    if (o_valid !== 1'b1 || u_I.data.data !== 8'hA5 || o_count !== CW'(1)) begin
      n_err++;
      $display("FAIL single_push: valid=%b data=%h count=%0d, want 1/a5/1",
               o_valid, u_I.data.data, o_count);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_vec++;
    if (!popped || obs_head !== exp_head) begin
      n_err++;
      $display("FAIL single_pop_data: got %h popped=%b, want %h", obs_head, popped, exp_head);
    end
    n_vec++;
    if (o_valid !== 1'b0 || u_I.data.data !== 8'h00 || o_count !== CW'(0)) begin
      n_err++;
      $display("FAIL single_empty: valid=%b data=%h count=%0d, want 0/00/0",
               o_valid, u_I.data.data, o_count);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0);
    n_vec++;
    if (o_count !== CW'(4) || o_wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full: count=%0d wr_ready=%b, want 4/0", o_count, o_wr_ready);
    end
    drive(1'b1, 8'h05, 1'b0);
    n_vec++;
    if (o_count !== CW'(4)) begin
      n_err++;
      $display("FAIL fill_refuse: count=%0d, want 4", o_count);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_vec++;
      if (!popped || obs_head !== exp_head || exp_head !== 8'(i)) begin
        n_err++;
        $display("FAIL fill_order[%0d]: got %h, want %h", i, obs_head, 8'(i));
      end
    end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h21 + 8'(i), 1'b0);
    drive(1'b1, 8'h05, 1'b1);
    n_vec++;
    if (!popped || obs_head !== 8'h21 || o_count !== CW'(3)) begin
      n_err++;
      $display("FAIL full_pop_push: head=%h count=%0d, want 21/3", obs_head, o_count);
    end
    drive(1'b1, 8'h05, 1'b0);
    n_vec++;
    if (o_count !== CW'(4)) begin
      n_err++;
      $display("FAIL full_repush: count=%0d, want 4", o_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      n_vec++;
      if (!popped || obs_head !== exp_head) begin
        n_err++;
        $display("FAIL full_drain[%0d]: got %h, want %h", i, obs_head, exp_head);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 1'b1);
      n_vec++;
      if (!popped || obs_head !== exp_head || o_count !== CW'(1)) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h count=%0d, want %h/1", i, obs_head, o_count, exp_head);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    n_vec++;
    if (!popped || obs_head !== 8'h19 || o_count !== CW'(0)) begin
      n_err++;
      $display("FAIL b2b_tail: got %h count=%0d, want 19/0", obs_head, o_count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h31 + 8'(i), 1'b0);
    i_rst_n = 1'b0;
    drive(1'b1, 8'h99, 1'b1);
    i_rst_n = 1'b1;
    #1;
    n_vec++;
    if (o_count !== CW'(0) || o_valid !== 1'b0 || u_I.data.data !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset: count=%0d valid=%b data=%h, want 0/0/00",
               o_count, o_valid, u_I.data.data);
    end
    // Push with a pop on an empty FIFO: the pop must be ignored.
    drive(1'b1, 8'h7E, 1'b1);
    n_vec++;
    if (o_valid !== 1'b1 || u_I.data.data !== 8'h7E || o_count !== CW'(1)) begin
      n_err++;
      $display("FAIL mid_repush: valid=%b data=%h count=%0d, want 1/7e/1",
               o_valid, u_I.data.data, o_count);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_vec++;
    if (!popped || obs_head !== exp_head || o_count !== CW'(0)) begin
      n_err++;
      $display("FAIL mid_drain: got %h count=%0d, want %h/0", obs_head, o_count, exp_head);
    end
  endtask

  initial begin
    @(posedge i_clk);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_full_pop_push();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
